// File: rtl/carregador_matriz_pkg.sv
// Shared definitions for the matrix loader and the determinant unit:
// size codes, bus geometry, element-count lookup and loader FSM states.
package pkg_matriz;

  localparam int unsigned LARGURA_ELEM = 8;
  localparam int unsigned MAX_ELEM     = 25;
  localparam int unsigned LARGURA_BUS  = LARGURA_ELEM * MAX_ELEM;

  localparam logic [1:0] TAM_2X2 = 2'b00;
  localparam logic [1:0] TAM_3X3 = 2'b01;
  localparam logic [1:0] TAM_4X4 = 2'b10;
  localparam logic [1:0] TAM_5X5 = 2'b11;

  typedef enum logic [1:0] {
    OCIOSO     = 2'b00,
    CARREGANDO = 2'b01,
    PRONTO     = 2'b10
  } estado_t;

  function automatic logic [4:0] num_elem(input logic [1:0] codigo);
    logic [4:0] n;
    case (codigo)
      TAM_2X2: n = 5'd4;
      TAM_3X3: n = 5'd9;
      TAM_4X4: n = 5'd16;
      TAM_5X5: n = 5'd25;
      default: n = 5'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/carregador_matriz_if.sv
// Element stream, size/start control and packed-matrix result of the loader.
interface carregador_matriz_if;
  import pkg_matriz::*;

  logic                   inicio;
  logic [1:0]             tamanho;
  logic [LARGURA_ELEM-1:0] elem;
  logic                   elem_valido;
  logic                   elem_pronto;
  logic                   liberar;
  logic [LARGURA_BUS-1:0] matriz;
  logic [1:0]             sinalizador;
  logic                   matriz_valida;
  logic                   ocupado;
  logic [4:0]             indice;

  modport master (
    output inicio, tamanho, elem, elem_valido, liberar,
    input  elem_pronto, matriz, sinalizador, matriz_valida, ocupado, indice
  );

  modport slave (
    input  inicio, tamanho, elem, elem_valido, liberar,
    output elem_pronto, matriz, sinalizador, matriz_valida, ocupado, indice
  );

endinterface

// File: rtl/carregador_matriz_contador.sv
// Element counter: slot index for the next write and a terminal flag that
// fires on the write that fills the last slot of the current matrix size.
module contador_elementos (
  input  logic       clk,
  input  logic       rst,
  input  logic       limpar,
  input  logic       habilitar,
  input  logic [4:0] ultimo,
  output logic [4:0] indice,
  output logic       terminal
);

  always_ff @(posedge clk) begin
    if (rst || limpar) begin
      indice <= '0;
    end else if (habilitar) begin
      indice <= indice + 5'd1;
    end
  end

  assign terminal = (indice == ultimo) && habilitar;

endmodule

// File: rtl/carregador_matriz.sv
// Matrix loader: accepts row-major elements over valid/ready, packs them into
// the 200-bit bus and holds the result valid until the consumer releases it.
module carregador_matriz
  import pkg_matriz::*;
(
  input  logic                clk,
  input  logic                rst,
  carregador_matriz_if.slave  bus
);

  estado_t                 estado, estado_prox;
  logic                    reiniciar;
  logic                    aceitar;
  logic                    terminal;
  logic [4:0]              indice;
  logic [4:0]              ultimo;
  logic [1:0]              sinalizador;
  logic [LARGURA_BUS-1:0]  matriz;
  logic [MAX_ELEM-1:0]     hab_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= OCIOSO;
    end else begin
      estado <= estado_prox;
    end
  end

  // A start request always wins over an element offered in the same cycle.
  always_comb begin
    estado_prox = estado;
    reiniciar   = 1'b0;
    aceitar     = 1'b0;
    case (estado)
      OCIOSO: begin
        if (bus.inicio) begin
          reiniciar   = 1'b1;
          estado_prox = CARREGANDO;
        end
      end
      CARREGANDO: begin
        if (bus.inicio) begin
          reiniciar = 1'b1;
        end else if (bus.elem_valido) begin
          aceitar = 1'b1;
          if (terminal) begin
            estado_prox = PRONTO;
          end
        end
      end
      PRONTO: begin
        if (bus.liberar) begin
          if (bus.inicio) begin
            reiniciar   = 1'b1;
            estado_prox = CARREGANDO;
          end else begin
            estado_prox = OCIOSO;
          end
        end
      end
      default: estado_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sinalizador <= TAM_2X2;
    end else if (reiniciar) begin
      sinalizador <= bus.tamanho;
    end
  end

  assign ultimo = num_elem(sinalizador) - 5'd1;

  contador_elementos u_contador (
    .clk       (clk),
    .rst       (rst),
    .limpar    (reiniciar),
    .habilitar (aceitar),
    .ultimo    (ultimo),
    .indice    (indice),
    .terminal  (terminal)
  );

  always_comb begin
    hab_byte = '0;
    for (int unsigned k = 0; k < MAX_ELEM; k++) begin
      if (aceitar && (indice == 5'(k))) begin
        hab_byte[k] = 1'b1;
      end
    end
  end

  // Each slot has its own fixed byte lane; the index only selects the enable.
  always_ff @(posedge clk) begin
    if (rst || reiniciar) begin
      matriz <= '0;
    end else begin
      for (int unsigned k = 0; k < MAX_ELEM; k++) begin
        if (hab_byte[k]) begin
          matriz[k*LARGURA_ELEM +: LARGURA_ELEM] <= bus.elem;
        end
      end
    end
  end

  assign bus.matriz        = matriz;
  assign bus.sinalizador   = sinalizador;
  assign bus.indice        = indice;
  assign bus.elem_pronto   = (estado == CARREGANDO);
  assign bus.matriz_valida = (estado == PRONTO);
  assign bus.ocupado       = (estado != OCIOSO);

endmodule

// File: tb/tb_carregador_matriz.sv
// Self-checking bench for carregador_matriz: directed scenarios plus random
// loads compared against a list-of-elements packing model.
module tb_carregador_matriz;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int unsigned n_tab [4] = '{4, 9, 16, 25};

  always #5 clk = ~clk;

  carregador_matriz_if bus ();

  carregador_matriz dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [199:0] empacotar(input logic [7:0] v [$]);
    logic [199:0] r;
    r = '0;
    for (int k = 0; k < v.size(); k++) r[k*8 +: 8] = v[k];
    return r;
  endfunction

  task automatic ciclo();
    @(posedge clk);
    #1;
  endtask

  task automatic iniciar(input logic [1:0] codigo);
    bus.inicio = 1'b1;
    bus.tamanho = codigo;
    ciclo();
    bus.inicio = 1'b0;
  endtask

  task automatic enviar(input logic [7:0] v);
    bus.elem = v;
    bus.elem_valido = 1'b1;
    ciclo();
    bus.elem_valido = 1'b0;
  endtask

  task automatic liberar_matriz();
    bus.liberar = 1'b1;
    ciclo();
    bus.liberar = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.matriz_valida, bus.elem_pronto, bus.ocupado, bus.indice, bus.sinalizador} !== 10'd0 || bus.matriz !== 200'd0) begin
      failures++;
      $display("FAIL reset_initial: valida=%b pronto=%b ocupado=%b indice=%0d sinal=%b matriz=%h expected all zero",
               bus.matriz_valida, bus.elem_pronto, bus.ocupado, bus.indice, bus.sinalizador, bus.matriz);
    end
    iniciar(2'b01);
    for (int i = 0; i < 5; i++) enviar(8'($urandom_range(1, 255)));
    checks++;
    if (bus.indice !== 5'd5 || bus.ocupado !== 1'b1 || bus.matriz_valida !== 1'b0) begin
      failures++;
      $display("FAIL reset_preload: indice=%0d ocupado=%b valida=%b expected 5/1/0", bus.indice, bus.ocupado, bus.matriz_valida);
    end
    rst = 1'b1;
    ciclo();
    rst = 1'b0;
    checks++;
    if ({bus.matriz_valida, bus.elem_pronto, bus.ocupado, bus.indice, bus.sinalizador} !== 10'd0 || bus.matriz !== 200'd0) begin
      failures++;
      $display("FAIL reset_midload: valida=%b pronto=%b ocupado=%b indice=%0d sinal=%b matriz=%h expected all zero",
               bus.matriz_valida, bus.elem_pronto, bus.ocupado, bus.indice, bus.sinalizador, bus.matriz);
    end
  endtask

  task automatic test_2x2_back_to_back();
    iniciar(2'b00);
    checks++;
    if (bus.elem_pronto !== 1'b1 || bus.indice !== 5'd0) begin
      failures++;
      $display("FAIL b2b_start: pronto=%b indice=%0d expected 1/0", bus.elem_pronto, bus.indice);
    end
    enviar(8'h03); enviar(8'hFE); enviar(8'h01);
    checks++;
    if (bus.matriz_valida !== 1'b0) begin
      failures++;
      $display("FAIL b2b_early_valid: valida=%b expected 0", bus.matriz_valida);
    end
    enviar(8'h04);
    checks++;
    if (bus.matriz[31:0] !== 32'h0401FE03 || bus.matriz[199:32] !== 168'd0 || bus.sinalizador !== 2'b00 ||
        bus.matriz_valida !== 1'b1 || bus.elem_pronto !== 1'b0 || bus.indice !== 5'd4) begin
      failures++;
      $display("FAIL b2b_result: matriz=%h sinal=%b valida=%b pronto=%b indice=%0d expected low 0401fe03, 00, 1, 0, 4",
               bus.matriz, bus.sinalizador, bus.matriz_valida, bus.elem_pronto, bus.indice);
    end
    liberar_matriz();
    checks++;
    if (bus.matriz_valida !== 1'b0 || bus.ocupado !== 1'b0) begin
      failures++;
      $display("FAIL b2b_release: valida=%b ocupado=%b expected 0/0", bus.matriz_valida, bus.ocupado);
    end
  endtask

  task automatic test_3x3_gaps();
    iniciar(2'b01);
    for (int i = 1; i <= 9; i++) begin
      checks++;
      if (bus.indice !== 5'(i - 1) || bus.matriz_valida !== 1'b0) begin
        failures++;
        $display("FAIL gaps_step%0d: indice=%0d valida=%b expected %0d/0", i, bus.indice, bus.matriz_valida, i - 1);
      end
      enviar(8'(i));
      if (i < 9) begin
        bus.elem = 8'hAA;
        ciclo();
      end
    end
    checks++;
    if (bus.matriz[71:0] !== 72'h090807060504030201 || bus.matriz[199:72] !== 128'd0 ||
        bus.indice !== 5'd9 || bus.matriz_valida !== 1'b1) begin
      failures++;
      $display("FAIL gaps_result: matriz=%h indice=%0d valida=%b expected low 090807060504030201, 9, 1",
               bus.matriz, bus.indice, bus.matriz_valida);
    end
    liberar_matriz();
  endtask

  task automatic test_abort();
    logic [7:0] q [$];
    iniciar(2'b11);
    for (int i = 0; i < 10; i++) enviar(8'($urandom_range(1, 255)));
    bus.inicio = 1'b1;
    bus.tamanho = 2'b00;
    bus.elem = 8'h55;
    bus.elem_valido = 1'b1;
    ciclo();
    bus.inicio = 1'b0;
    bus.elem_valido = 1'b0;
    checks++;
    if (bus.indice !== 5'd0 || bus.matriz !== 200'd0 || bus.sinalizador !== 2'b00 || bus.elem_pronto !== 1'b1) begin
      failures++;
      $display("FAIL abort_restart: indice=%0d matriz=%h sinal=%b pronto=%b expected 0/0/00/1",
               bus.indice, bus.matriz, bus.sinalizador, bus.elem_pronto);
    end
    for (int i = 0; i < 4; i++) begin
      q.push_back(8'($urandom));
      enviar(q[i]);
    end
    checks++;
    if (bus.matriz !== empacotar(q) || bus.matriz_valida !== 1'b1) begin
      failures++;
      $display("FAIL abort_result: matriz=%h valida=%b expected %h/1", bus.matriz, bus.matriz_valida, empacotar(q));
    end
    liberar_matriz();
  endtask

  task automatic test_pronto_hold();
    logic [7:0] q [$];
    logic [199:0] esperado;
    iniciar(2'b10);
    for (int i = 0; i < 16; i++) begin
      q.push_back(8'($urandom));
      enviar(q[i]);
    end
    esperado = empacotar(q);
    for (int c = 0; c < 5; c++) begin
      bus.elem = 8'h7F;
      bus.elem_valido = 1'b1;
      bus.inicio = 1'b1;
      bus.tamanho = 2'($urandom);
      ciclo();
      checks++;
      if (bus.matriz !== esperado || bus.elem_pronto !== 1'b0 || bus.matriz_valida !== 1'b1 || bus.sinalizador !== 2'b10) begin
        failures++;
        $display("FAIL hold_c%0d: matriz=%h pronto=%b valida=%b sinal=%b expected %h/0/1/10",
                 c, bus.matriz, bus.elem_pronto, bus.matriz_valida, bus.sinalizador, esperado);
      end
    end
    bus.elem_valido = 1'b0;
    bus.inicio = 1'b0;
  endtask

  task automatic test_release_restart();
    logic [7:0] q [$];
    bus.liberar = 1'b1;
    bus.inicio = 1'b1;
    bus.tamanho = 2'b11;
    ciclo();
    bus.liberar = 1'b0;
    bus.inicio = 1'b0;
    checks++;
    if (bus.ocupado !== 1'b1 || bus.elem_pronto !== 1'b1 || bus.matriz_valida !== 1'b0 ||
        bus.matriz !== 200'd0 || bus.indice !== 5'd0 || bus.sinalizador !== 2'b11) begin
      failures++;
      $display("FAIL restart_state: ocupado=%b pronto=%b valida=%b matriz=%h indice=%0d sinal=%b expected 1/1/0/0/0/11",
               bus.ocupado, bus.elem_pronto, bus.matriz_valida, bus.matriz, bus.indice, bus.sinalizador);
    end
    for (int i = 0; i < 25; i++) begin
      q.push_back(8'($urandom));
      enviar(q[i]);
      if (i == 23) begin
        checks++;
        if (bus.matriz_valida !== 1'b0) begin
          failures++;
          $display("FAIL restart_early: valida=%b expected 0 at cycle 25", bus.matriz_valida);
        end
      end
    end
    checks++;
    if (bus.matriz_valida !== 1'b1 || bus.matriz !== empacotar(q) || bus.indice !== 5'd25) begin
      failures++;
      $display("FAIL restart_result: valida=%b indice=%0d matriz=%h expected 1/25/%h",
               bus.matriz_valida, bus.indice, bus.matriz, empacotar(q));
    end
    liberar_matriz();
  endtask

  task automatic test_random_loads();
    for (int it = 0; it < 8; it++) begin
      logic [7:0] q [$];
      logic [1:0] codigo;
      int unsigned n;
      codigo = 2'($urandom);
      n = n_tab[codigo];
      iniciar(codigo);
      while (q.size() < int'(n)) begin
        checks++;
        if (bus.elem_pronto !== 1'b1 || bus.indice !== 5'(q.size())) begin
          failures++;
          $display("FAIL rand%0d_load: pronto=%b indice=%0d expected 1/%0d", it, bus.elem_pronto, bus.indice, q.size());
        end
        bus.elem = 8'($urandom);
        bus.elem_valido = 1'($urandom);
        bus.liberar = 1'($urandom);
        if (bus.elem_valido) q.push_back(bus.elem);
        ciclo();
      end
      bus.elem_valido = 1'b0;
      bus.liberar = 1'b0;
      for (int w = 0; w < int'($urandom_range(1, 3)); w++) begin
        checks++;
        if (bus.matriz_valida !== 1'b1 || bus.matriz !== empacotar(q) || bus.sinalizador !== codigo) begin
          failures++;
          $display("FAIL rand%0d_result: valida=%b sinal=%b matriz=%h expected 1/%b/%h",
                   it, bus.matriz_valida, bus.sinalizador, bus.matriz, codigo, empacotar(q));
        end
        ciclo();
      end
      liberar_matriz();
      checks++;
      if (bus.ocupado !== 1'b0 || bus.matriz_valida !== 1'b0) begin
        failures++;
        $display("FAIL rand%0d_release: ocupado=%b valida=%b expected 0/0", it, bus.ocupado, bus.matriz_valida);
      end
    end
  endtask

  initial begin
    bus.inicio = 1'b0;
    bus.tamanho = 2'b00;
    bus.elem = '0;
    bus.elem_valido = 1'b0;
    bus.liberar = 1'b0;
    ciclo();
    ciclo();
    rst = 1'b0;
    test_reset();
    test_2x2_back_to_back();
    test_3x3_gaps();
    test_abort();
    test_pronto_hold();
    test_release_restart();
    test_random_loads();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
